// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants for uart_periph: register offsets from ADDR_BASE,
//   CON bit positions, TX/RX state encodings and the frame length.
//   Build option: UART_PARITY_EN adds an even parity bit between the data
//   bits and the stop bit (11-bit frame instead of 8N1).
package uart_pkg;

    localparam logic [31:0] OFF_TXD = 32'd0;
    localparam logic [31:0] OFF_RXD = 32'd4;
    localparam logic [31:0] OFF_CON = 32'd8;

    localparam int CON_TX_IE   = 0;
    localparam int CON_RX_IE   = 1;
    localparam int CON_RX_DONE = 2;
    localparam int CON_TX_DONE = 3;
    localparam int CON_TX_BUSY = 4;
    localparam int CON_RX_ERR  = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY = ST_PARITY,
`endif
        TX_STOP   = ST_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = ST_IDLE,
        RX_START  = ST_START,
        RX_DATA   = ST_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY = ST_PARITY,
`endif
        RX_STOP   = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit-period timer. Counts 0..limit-1 and pulses tick on the last count,
//   wrapping to 0 on the same edge. limit is BAUD_DIV, or BAUD_DIV>>1 while
//   half is high (used to reach the middle of the RX start bit).
// Ports
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   start  in  restart the count from 0 on the next edge
//   half   in  select the half-bit terminal count
//   tick   out terminal count reached this cycle
module uart_bit_timer #(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic half,
    output logic tick
);

    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_TC = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_TC = CW'((BAUD_DIV >> 1) - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == (half ? HALF_TC : FULL_TC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_periph.sv
// uart_periph
//   Memory-mapped UART on the CPU load/store port. TXD (base) starts a
//   frame, RXD (base+4) holds the last good byte, CON (base+8) holds the
//   interrupt enables and the sticky status flags.
//   Build option: UART_PARITY_EN selects an 11-bit frame with even parity.
// Ports
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   rd, wr   in   bus read / write strobes
//   addr     in   byte address (word aligned)
//   wdata    in   write data ([7:0] for TXD, [1:0] for CON)
//   rdata    out  combinational read data, 0 when not addressed
//   uart_rx  in   serial input, asynchronous
//   uart_tx  out  serial output, idle high
//   irqout   out  level interrupt request
//
// TX / RX state | meaning
//   IDLE        | line idle; TX waits for a TXD write, RX for a falling edge
//   START       | start bit; RX re-checks the line at half a bit
//   DATA        | 8 data bits, LSB first
//   PARITY      | even parity bit (UART_PARITY_EN only)
//   STOP        | stop bit; TX raises tx_done, RX commits or flags rx_err
module uart_periph
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV  = 5208,
    parameter logic [31:0] ADDR_BASE = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);

    logic        hit_txd, hit_rxd, hit_con;
    logic        txd_wr, con_wr, con_rd;
    logic [7:0]  txd_q, rxd_q;
    logic        tx_ie, rx_ie, rx_done, tx_done, rx_err, tx_busy;
    logic        tx_done_set, rx_done_set, rx_err_set;
    logic [31:0] con_val;
    logic        unused_wdata;

    tx_state_t   tx_state, tx_next;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_line_d, tx_tmr_start, tx_tick;

    rx_state_t   rx_state, rx_next;
    logic        rx_meta, rx_sync, rx_prev;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_perr_q, rx_perr_d;
    logic        rx_tmr_start, rx_half, rx_tick;

    // ---------------- bus decode and registers ----------------
    assign hit_txd = (addr == ADDR_BASE + OFF_TXD);
    assign hit_rxd = (addr == ADDR_BASE + OFF_RXD);
    assign hit_con = (addr == ADDR_BASE + OFF_CON);
    assign txd_wr  = wr & hit_txd;
    assign con_wr  = wr & hit_con;
    assign con_rd  = rd & hit_con;

    // Upper write-data bits have no destination in this block.
    assign unused_wdata = ^wdata[31:8];

    assign tx_busy = (tx_state != TX_IDLE);

    always_comb begin
        con_val              = '0;
        con_val[CON_TX_IE]   = tx_ie;
        con_val[CON_RX_IE]   = rx_ie;
        con_val[CON_RX_DONE] = rx_done;
        con_val[CON_TX_DONE] = tx_done;
        con_val[CON_TX_BUSY] = tx_busy;
        con_val[CON_RX_ERR]  = rx_err;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_txd)      rdata = {24'h0, txd_q};
            else if (hit_rxd) rdata = {24'h0, rxd_q};
            else if (hit_con) rdata = con_val;
        end
    end

    // Status flags: a set event on the same edge as a CON read wins, so
    // no completion is ever lost to a concurrent poll.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd_q   <= '0;
            rxd_q   <= '0;
            tx_ie   <= 1'b0;
            rx_ie   <= 1'b0;
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            rx_err  <= 1'b0;
            irqout  <= 1'b0;
        end else begin
            if (txd_wr) txd_q <= wdata[7:0];
            if (con_wr) begin
                tx_ie <= wdata[CON_TX_IE];
                rx_ie <= wdata[CON_RX_IE];
            end
            if (rx_done_set) rxd_q <= rx_shift_q;

            if (rx_done_set) rx_done <= 1'b1;
            else if (con_rd) rx_done <= 1'b0;
            if (tx_done_set) tx_done <= 1'b1;
            else if (con_rd) tx_done <= 1'b0;
            if (rx_err_set)  rx_err  <= 1'b1;
            else if (con_rd) rx_err  <= 1'b0;

            irqout <= (tx_ie & tx_done) | (rx_ie & rx_done);
        end
    end

    // ---------------- transmitter ----------------
    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
        .clk   (clk),
        .reset (reset),
        .start (tx_tmr_start),
        .half  (1'b0),
        .tick  (tx_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            tx_data_q <= '0;
            tx_bit_q  <= '0;
            uart_tx   <= 1'b1;
        end else begin
            tx_state  <= tx_next;
            tx_data_q <= tx_data_d;
            tx_bit_q  <= tx_bit_d;
            uart_tx   <= tx_line_d;
        end
    end

    // uart_tx is registered: each branch chooses the line level for the
    // state being entered.
    always_comb begin
        tx_next      = tx_state;
        tx_data_d    = tx_data_q;
        tx_bit_d     = tx_bit_q;
        tx_line_d    = uart_tx;
        tx_tmr_start = 1'b0;
        tx_done_set  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (txd_wr) begin
                    tx_next      = TX_START;
                    tx_data_d    = wdata[7:0];
                    tx_line_d    = 1'b0;
                    tx_tmr_start = 1'b1;
                end
            end
            TX_START: if (tx_tick) begin
                tx_next   = TX_DATA;
                tx_bit_d  = 3'd0;
                tx_line_d = tx_data_q[0];
            end
            TX_DATA: if (tx_tick) begin
                if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_next   = TX_PARITY;
                    tx_line_d = ^tx_data_q;
`else
                    tx_next   = TX_STOP;
                    tx_line_d = 1'b1;
`endif
                end else begin
                    tx_bit_d  = tx_bit_q + 3'd1;
                    tx_line_d = tx_data_q[tx_bit_d];
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_tick) begin
                tx_next   = TX_STOP;
                tx_line_d = 1'b1;
            end
`endif
            TX_STOP: if (tx_tick) begin
                tx_next     = TX_IDLE;
                tx_line_d   = 1'b1;
                tx_done_set = 1'b1;
            end
            default: begin
                tx_next   = TX_IDLE;
                tx_line_d = 1'b1;
            end
        endcase
    end

    // ---------------- receiver ----------------
    assign rx_half = (rx_state == RX_START);

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
        .clk   (clk),
        .reset (reset),
        .start (rx_tmr_start),
        .half  (rx_half),
        .tick  (rx_tick)
    );

    // Synchronizer and edge-detect flops reset high to match an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_next;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_comb begin
        rx_next      = rx_state;
        rx_shift_d   = rx_shift_q;
        rx_bit_d     = rx_bit_q;
        rx_perr_d    = rx_perr_q;
        rx_tmr_start = 1'b0;
        rx_done_set  = 1'b0;
        rx_err_set   = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_sync) begin
                rx_next      = RX_START;
                rx_tmr_start = 1'b1;
            end
            RX_START: if (rx_tick) begin
                if (!rx_sync) begin
                    rx_next   = RX_DATA;
                    rx_bit_d  = 3'd0;
                    rx_perr_d = 1'b0;
                end else begin
                    rx_next = RX_IDLE;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_sync, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    rx_next = RX_PARITY;
`else
                    rx_next = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_tick) begin
                rx_perr_d = rx_sync ^ (^rx_shift_q);
                rx_next   = RX_STOP;
            end
`endif
            RX_STOP: if (rx_tick) begin
                rx_next = RX_IDLE;
                if (rx_sync && !rx_perr_q) rx_done_set = 1'b1;
                else                       rx_err_set  = 1'b1;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

endmodule
